bsg_scan_pipe: RTL

Pipelined, elastic prefix-scan engine over a `width_p`-bit vector. Each transaction selects OR, AND, XOR or passthrough, and inclusive or exclusive scan. The block is the registered, handshaked successor to the combinational scan. It serves wide round-robin arbiters, parity/one-hot logic and free-list search, where a full log-depth scan does not fit in one cycle. Throughput is one transaction per cycle, with full backpressure.

---
 rtl/bsg_scan_pkg.sv | 22 ++
 rtl/bsg_scan_pipe_level.sv | 34 +++
 rtl/bsg_scan_pipe.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bsg_scan_pkg.sv
// Shared types for the pipelined prefix-scan engine: operation encoding,
// per-transaction mode and the identity element of each operation.
package bsg_scan_pkg;

  typedef enum logic [1:0] {
    SCAN_OR   = 2'b00,
    SCAN_AND  = 2'b01,
    SCAN_XOR  = 2'b10,
    SCAN_PASS = 2'b11
  } bsg_scan_op_e;

  typedef struct packed {
    bsg_scan_op_e op;
    logic         excl;
  } bsg_scan_mode_s;

  // Value that leaves an operand unchanged; also used to fill vacated bits.
  function automatic logic bsg_scan_identity(input bsg_scan_op_e op);
    return (op == SCAN_AND);
  endfunction

endpackage

// File: rtl/bsg_scan_pipe_level.sv
// One combinational log-step of the scan: t op (t >> shift_p), identity-filled.
module bsg_scan_pipe_level
  import bsg_scan_pkg::*;
#(
  parameter int width_p = 16,
  parameter int shift_p = 1
) (
  input  bsg_scan_mode_s       mode_i,
  input  logic [width_p-1:0]   data_i,
  output logic [width_p-1:0]   data_o
);

  logic [width_p-1:0] fill;
  logic [width_p-1:0] shifted;
  logic               unused_excl;

  // The exclusive pre-shift happens before level 0, so excl is not needed here.
  assign unused_excl = mode_i.excl;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    data_o  = data_i;
    fill    = {width_p{bsg_scan_identity(mode_i.op)}};
    shifted = (data_i >> shift_p) | (fill & ~({width_p{1'b1}} >> shift_p));
    case (mode_i.op)
      SCAN_OR:  data_o = data_i | shifted;
      SCAN_AND: data_o = data_i & shifted;
      SCAN_XOR: data_o = data_i ^ shifted;
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/bsg_scan_pipe.sv
// Elastic, pipelined prefix scan (OR/AND/XOR/pass, inclusive or exclusive)
// with valid/ready input, valid/yumi output and one transaction per cycle.
module bsg_scan_pipe
  import bsg_scan_pkg::*;
#(
  parameter int width_p            = 16,
  parameter int levels_per_stage_p = 1,
  parameter bit lo_to_hi_p         = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic [1:0]         op_i,
  input  logic               excl_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int levels_lp = $clog2(width_p);
  localparam int stages_lp = (levels_lp + levels_per_stage_p - 1) / levels_per_stage_p;

  function automatic logic [width_p-1:0] rev(input logic [width_p-1:0] x);
    logic [width_p-1:0] r;
    for (int i = 0; i < width_p; i++) r[i] = x[width_p-1-i];
    return r;
  endfunction

  // Index of the final log-step computed ahead of stage s's register.
  function automatic int stage_last(input int s);
    int hi;
    hi = (s + 1) * levels_per_stage_p;
    return ((hi < levels_lp) ? hi : levels_lp) - 1;
  endfunction

  bsg_scan_mode_s     in_mode;
  logic [width_p-1:0] in_rev;
  logic [width_p-1:0] in_pre;

  assign in_mode = '{op: bsg_scan_op_e'(op_i), excl: excl_i};
  assign in_rev  = lo_to_hi_p ? rev(data_i) : data_i;

  // Exclusive scan: shift one place toward the tail, identity enters at the head.
  assign in_pre = (in_mode.excl && (in_mode.op != SCAN_PASS))
                ? {bsg_scan_identity(in_mode.op), in_rev[width_p-1:1]}
                : in_rev;

  logic [width_p-1:0] lvl_in   [levels_lp];
  logic [width_p-1:0] lvl_out  [levels_lp];
  bsg_scan_mode_s     lvl_mode [levels_lp];

  logic [stages_lp-1:0] v_r;
  logic [width_p-1:0]   data_r        [stages_lp];
  bsg_scan_mode_s       mode_r        [stages_lp];
  logic [width_p-1:0]   stage_in_data [stages_lp];
  bsg_scan_mode_s       stage_in_mode [stages_lp];

  for (genvar j = 0; j < levels_lp; j++) begin : g_level
    if (j == 0) begin : g_head0
      assign lvl_in[j]   = in_pre;
      assign lvl_mode[j] = in_mode;
    end else if ((j % levels_per_stage_p) == 0) begin : g_head
      assign lvl_in[j]   = data_r[j/levels_per_stage_p - 1];
      assign lvl_mode[j] = mode_r[j/levels_per_stage_p - 1];
    end else begin : g_chain
      assign lvl_in[j]   = lvl_out[j-1];
      assign lvl_mode[j] = lvl_mode[j-1];
    end

    bsg_scan_pipe_level #(
      .width_p (width_p),
      .shift_p (1 << j)
    ) u_level (
      .mode_i (lvl_mode[j]),
      .data_i (lvl_in[j]),
      .data_o (lvl_out[j])
    );
  end

  for (genvar s = 0; s < stages_lp; s++) begin : g_stage_in
    localparam int last_lp = stage_last(s);
    assign stage_in_data[s] = lvl_out[last_lp];
    assign stage_in_mode[s] = lvl_mode[last_lp];
  end

  // Advance ripples back from the consumer so a draining pipe accepts at once.
  logic [stages_lp-1:0] adv;
  logic [stages_lp-1:0] open_w;
  logic [stages_lp:0]   src_v;
  logic                 down_ok;

  always_comb begin
    adv     = '0;
    down_ok = yumi_i;
    for (int s = stages_lp - 1; s >= 0; s--) begin
      adv[s]  = v_r[s] & down_ok;
      down_ok = ~v_r[s] | down_ok;
    end
  end

  assign open_w  = ~v_r | adv;
  assign src_v   = {adv, v_i};
  assign ready_o = open_w[0];

  // NOTE: state uses non-blocking assignments so every stage samples the
  // pre-edge value of its upstream neighbour. Data and mode are reset as
  // well as valid, so data_o reads 0 straight out of reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r <= '0;
      for (int s = 0; s < stages_lp; s++) begin
        data_r[s] <= '0;
        mode_r[s] <= '0;
      end
    end else begin
      for (int s = 0; s < stages_lp; s++) begin
        if (open_w[s]) begin
          v_r[s] <= src_v[s];
          if (src_v[s]) begin
            data_r[s] <= stage_in_data[s];
            mode_r[s] <= stage_in_mode[s];
          end
        end
      end
    end
  end

  assign v_o    = v_r[stages_lp-1];
  assign data_o = lo_to_hi_p ? rev(data_r[stages_lp-1]) : data_r[stages_lp-1];

endmodule
